// File: rtl/dot_product_pe.sv
// dot_product_pe: signed K-element multiply-accumulate PE with an IDLE/MAC/OUT handshake FSM.
// Define PE_SATURATE_EN to clamp each accumulate to the signed ACC_W range instead of wrapping.
module dot_product_pe #(
    parameter int K      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_PE,
    output logic                     PE_ready,
    input  logic signed [DATA_W-1:0] a_data,
    input  logic signed [DATA_W-1:0] b_data,
    input  logic                     operands_valid,
    output logic                     operands_ready,
    output logic signed [ACC_W-1:0]  result,
    output logic                     result_valid,
    input  logic                     result_ready
);
    localparam int CNT_W = $clog2(K) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]                 state;
    logic [CNT_W-1:0]           cnt;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [2*DATA_W-1:0] prod;
    logic                       beat;
    logic                       last;

    assign prod = (2*DATA_W)'(a_data) * (2*DATA_W)'(b_data);

`ifdef PE_SATURATE_EN
    // one guard bit exposes overflow; the clamped value then feeds the next accumulate
    logic signed [ACC_W:0] sum;
    assign sum      = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    assign acc_next = (sum[ACC_W] != sum[ACC_W-1])
                    ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                    : sum[ACC_W-1:0];
`else
    assign acc_next = acc + ACC_W'(prod);
`endif

    assign beat           = (state == MAC) && operands_valid;
    assign last           = cnt == CNT_W'(K - 1);
    assign PE_ready       = state == IDLE;
    assign operands_ready = state == MAC;
    assign result_valid   = state == OUT;
    assign result         = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start_PE) begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= MAC;
                end
                MAC: if (beat) begin
                    acc   <= acc_next;
                    cnt   <= cnt + CNT_W'(1);
                    state <= last ? OUT : MAC;
                end
                OUT: if (result_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dot_product_pe.md
DOT_PRODUCT_PE -- requirements
Module: dot_product_pe

Interface
REQ-001 Parameter K, default 4: dot-product length (operand pairs per result), K >= 1.
REQ-002 Parameter DATA_W, default 8: signed operand width.
REQ-003 Parameter ACC_W, default 20: signed accumulator/result width, ACC_W >= 2*DATA_W.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 start_PE  input  1  one-cycle request from iteration control to begin one dot product.
REQ-007 PE_ready  output  1  high when idle and able to accept start_PE.
REQ-008 a_data  input  DATA_W  signed row element.
REQ-009 b_data  input  DATA_W  signed column element.
REQ-010 operands_valid  input  1  a_data/b_data valid this cycle.
REQ-011 operands_ready  output  1  block accepts an operand pair this cycle.
REQ-012 result  output  ACC_W  signed dot-product result.
REQ-013 result_valid  output  1  result held valid for the downstream FIFO.
REQ-014 result_ready  input  1  downstream FIFO can accept (driven from ~fifo_full).

Function
REQ-015 The block SHALL implement states IDLE, MAC, OUT; any other encoding SHALL go to IDLE.
REQ-016 In IDLE: PE_ready=1, operands_ready=0, result_valid=0; start_PE=1 SHALL clear accumulator and beat counter and go to MAC next cycle.
REQ-017 start_PE while in MAC or OUT SHALL be ignored, with no effect on state, counter or accumulator.
REQ-018 In MAC: operands_ready=1, PE_ready=0; a beat is operands_valid & operands_ready.
REQ-019 Each beat SHALL add sign-extended signed(a_data)*signed(b_data) to the accumulator and increment the beat counter ($clog2(K)+1 bits, 1 bit minimum).
REQ-020 Cycles with operands_valid=0 in MAC SHALL leave accumulator and counter unchanged, so bubbles do not alter the result.
REQ-021 The K-th beat SHALL move the FSM to OUT; result_valid SHALL rise the cycle after that beat, with result including the K-th product.
REQ-022 In OUT: result_valid=1, operands_ready=0, PE_ready=0; result SHALL stay stable until result_ready=1.
REQ-023 result_valid & result_ready SHALL return the FSM to IDLE; PE_ready SHALL be 1 the following cycle.
REQ-024 K=1 SHALL work: one beat, then OUT.
REQ-025 Minimum per-result occupancy SHALL be K MAC cycles + 1 OUT cycle, followed by IDLE.
REQ-026 Accumulation without PE_SATURATE_EN SHALL wrap modulo 2^ACC_W in two's complement.

Reset
REQ-027 While rst_n=0: state=IDLE, accumulator=0, counter=0, result=0, result_valid=0, operands_ready=0, PE_ready=1.
REQ-028 Reset asserted mid-MAC or mid-OUT SHALL discard the partial or pending result; the next start_PE SHALL compute from a zero accumulator.

Configuration
REQ-029 Macro PE_SATURATE_EN defined: each accumulate SHALL clamp to the signed ACC_W range (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)), and clamping is sticky only through the value itself.
REQ-030 Macro PE_SATURATE_EN undefined: no clamp logic SHALL be present, and wrap per REQ-026 applies; the interface is identical in both builds.

Verification
REQ-031 K=4, a={1,2,3,4}, b={5,6,7,8}, contiguous beats -> result=70, result_valid 1 cycle after 4th beat.
REQ-032 K=4, a=b={-128,-128,-128,-128} -> result=65536; a={-1,2,-3,4}, b={1,1,1,1} -> result=2.
REQ-033 result_ready=0 for 5 cycles in OUT with start_PE pulsed -> result_valid held, result stable, PE_ready=0, start ignored; ready=1 -> IDLE and PE_ready=1 next cycle.
REQ-034 Test REQ-031 operands with operands_valid=0 bubbles of 1-3 cycles between beats -> result=70.
REQ-035 ACC_W=16, K=4, a=b=127 x4 -> result=-1020 without macro; result=32767 with PE_SATURATE_EN.
REQ-036 rst_n low after 2 beats, then new start with REQ-031 operands -> all outputs at reset values during reset, then result=70.
